// File: rtl/aes_inv_cipher_core_if.sv
// rtl/aes_inv_cipher_core_if.sv - ciphertext/plaintext handshakes and round-key port of the inverse cipher
interface aes_inv_cipher_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  modport master (
    output in_valid, ciphertext, rk, out_ready,
    input  in_ready, rk_idx, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, rk, out_ready,
    output in_ready, rk_idx, out_valid, plaintext
  );
endinterface

// File: rtl/aes_inv_cipher_core.sv
// rtl/aes_inv_cipher_core.sv - iterative AES-128 inverse cipher, one inverse round per clock
// Bytes are column-major: (row r, col c) sits at [127-8*(4c+r) -: 8].

module Inverse_mix_columns (
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] a;
    p = '0;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_data[127-32*c -: 8];
    assign w_a1 = i_data[119-32*c -: 8];
    assign w_a2 = i_data[111-32*c -: 8];
    assign w_a3 = i_data[103-32*c -: 8];
    assign o_data[127-32*c -: 8] = gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb) ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9);
    assign o_data[119-32*c -: 8] = gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he) ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd);
    assign o_data[111-32*c -: 8] = gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9) ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb);
    assign o_data[103-32*c -: 8] = gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd) ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he);
  end
endmodule

module aes_inv_cipher_core #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_cipher_core_if.slave  bus,
  output logic                  busy
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  localparam logic [3:0] LAST_KEY    = 4'(NR);
  localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [3:0]   r_rk_idx;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  // InvShiftRows folded into the S-box input select: out(r,c) = in(r,(c-r) mod 4)
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4*((COL - ROW + 4) % 4) + ROW;
    assign w_isb[127-8*gi -: 8] = inv_sbox(r_state[127-8*SRC -: 8]);
  end

  assign w_ark = w_isb ^ bus.rk;

  Inverse_mix_columns u_imc (
    .i_data (w_ark),
    .o_data (w_imc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_round     <= '0;
      r_rk_idx    <= LAST_KEY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_state    <= bus.ciphertext ^ bus.rk;
            r_round    <= FIRST_ROUND;
            r_rk_idx   <= FIRST_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= S_ROUND;
          end
        end
        S_ROUND: begin
          // rk_idx tracks the round counter so the key store answers for the next round
          if (r_round == 4'd0) begin
            r_state     <= w_ark;
            r_out_valid <= 1'b1;
            r_rk_idx    <= 4'd0;
            r_fsm       <= S_DONE;
          end else begin
            r_state  <= w_imc;
            r_round  <= r_round - 4'd1;
            r_rk_idx <= r_round - 4'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_rk_idx    <= LAST_KEY;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.rk_idx    = r_rk_idx;
  assign bus.plaintext = r_state;
  assign busy          = r_busy;
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb/tb_aes_inv_cipher_core.sv - directed and randomized checks of aes_inv_cipher_core
// Expected plaintexts come from FIPS-197 C.1 and a forward AES-128 encryptor in the bench.
module tb_aes_inv_cipher_core;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_R0  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] PT2    = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [127:0] ks [11];
  logic [127:0] last_pt;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_acc = 0, n_out = 0, exp_acc = 0, exp_out = 0;
  int acc_cyc[$];
  logic [127:0] out_q[$];

  aes_inv_cipher_core_if bus();

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  assign bus.rk = (bus.rk_idx <= 4'd10) ? ks[bus.rk_idx] : '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc_block(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ ks[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = sb(s[127-8*(4*(((i/4) + (i%4)) % 4) + (i%4)) -: 8]);
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = t ^ ks[rd];
    end
    return s;
  endfunction

  // Records handshakes that fire on the coming edge, then advances to 1 ns past it.
  task automatic step();
    if (!rst && bus.in_valid && bus.in_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      last_pt = bus.plaintext;
      out_q.push_back(bus.plaintext);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string tag, input bit stall);
    int a0, o0;
    a0 = n_acc;
    o0 = n_out;
    bus.in_valid = 1'b1;
    bus.ciphertext = ct;
    for (int i = 0; i < 40 && n_acc == a0; i++) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.ciphertext = rnd128();
    for (int i = 0; i < 300 && n_out == o0; i++) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    exp_acc++;
    exp_out++;
    chk({tag, "_handshake"}, 128'(n_out - o0), 128'd1);
    chk(tag, last_pt, exp);
  endtask

  initial begin
    logic [127:0] ct2, pt;
    bus.in_valid = 1'b0;
    bus.ciphertext = '0;
    bus.out_ready = 1'b1;
    key_expand(C1_KEY);
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
    chk("rst_plaintext", bus.plaintext, 128'd0);
    rst = 1'b0;

    // FIPS-197 C.1, step by step
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    chk("c1_rk_idle", 128'(bus.rk_idx), 128'd10);
    step();
    exp_acc++;
    bus.in_valid = 1'b0;
    bus.ciphertext = rnd128();
    chk("c1_first_edge", bus.plaintext, C1_R0);
    chk("c1_rk_9", 128'(bus.rk_idx), 128'd9);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("c1_rk_seq", 128'(bus.rk_idx), 128'(9 - i));
      chk("c1_no_early_valid", 128'(bus.out_valid), 128'd0);
    end
    step();
    chk("c1_valid_at_10", 128'(bus.out_valid), 128'd1);
    chk("c1_plaintext", bus.plaintext, C1_PT);
    chk("c1_done_in_ready", 128'(bus.in_ready), 128'd0);
    step();
    exp_out++;
    chk("c1_busy_after", 128'(busy), 128'd0);
    chk("c1_in_ready_after", 128'(bus.in_ready), 128'd1);
    chk("c1_valid_after", 128'(bus.out_valid), 128'd0);

    // Backpressure: hold the result for 20 cycles while another request waits
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    step();
    exp_acc++;
    bus.ciphertext = rnd128();
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_plaintext", bus.plaintext, C1_PT);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    exp_out++;
    chk("bp_release_idle", 128'({busy, bus.in_ready, bus.out_valid}), 128'b010);

    // Back-to-back with in_valid held high
    pt = PT2;
    ct2 = enc_block(pt);
    acc_cyc.delete();
    out_q.delete();
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    for (int i = 0; i < 60 && out_q.size() < 2; i++) begin
      step();
      if (acc_cyc.size() == 1) bus.ciphertext = ct2;
      if (acc_cyc.size() >= 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    exp_acc += 2;
    exp_out += 2;
    chk("b2b_outputs", 128'(out_q.size()), 128'd2);
    if (out_q.size() == 2 && acc_cyc.size() == 2) begin
      chk("b2b_pt1", out_q[0], C1_PT);
      chk("b2b_pt2", out_q[1], PT2);
      chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    end

    // Reset at round counter 5, with in_valid high during reset
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    step();
    exp_acc++;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && bus.rk_idx != 4'd5; i++) step();
    chk("mid_rst_at_5", 128'(bus.rk_idx), 128'd5);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    step();
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_state", bus.plaintext, 128'd0);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'd10);
    step();
    chk("rst_beats_in_valid", 128'(busy), 128'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    run_block(C1_CT, C1_PT, "c1_after_rst", 1'b0);

    // Random keys and plaintexts with random output stalls
    for (int k = 0; k < 1000; k++) begin
      key_expand(rnd128());
      pt = rnd128();
      run_block(enc_block(pt), pt, "rand", 1'b1);
    end

    chk("accept_count", 128'(n_acc), 128'(exp_acc));
    chk("output_count", 128'(n_out), 128'(exp_out));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_core.md
Name: aes_inv_cipher_core

Overview:
- Iterative AES-128 decryption datapath. Performs one inverse round per clock.
- Sits directly upstream of, and instantiates, Inverse_mix_columns. The block computes InvShiftRows, InvSubBytes and AddRoundKey, then feeds the result to Inverse_mix_columns and registers its output.
- Ciphertext enters through a valid/ready handshake. Round keys come from an external key store, addressed by rk_idx. Plaintext leaves through a second valid/ready handshake.

Parameters:
- NR, 10, number of rounds (AES-128). Only the value 10 is supported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext present
- in_ready  output  1  core can accept ciphertext
- ciphertext  input  128  block to decrypt, byte 0 at [127:120]
- rk_idx  output  4  round-key index requested this cycle, 0..10
- rk  input  128  round key for rk_idx, valid combinationally in the same cycle
- out_valid  output  1  plaintext valid
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  128  decrypted block, driven from the state register
- busy  output  1  high while not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over all other inputs.
- Reset values: state=IDLE, state register=0, round counter=0, in_ready=1, out_valid=0, busy=0, rk_idx=10, plaintext=0.
- Byte layout: column-major. Byte (row r, col c) occupies bits [127-8*(4c+r) -: 8]. Column c occupies bits [127-32c : 96-32c], which is the column layout Inverse_mix_columns expects.
- InvShiftRows: out(r,c) = in(r,(c-r) mod 4).
- InvSubBytes: 16 instances of the team's inverse S-box, one per byte.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=10.
  - On in_valid & in_ready: state_reg <= ciphertext ^ rk, round counter <= 9, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx = round counter.
  - Counter 9..1: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk), counter decrements.
  - Counter 0: state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk, with no InvMixColumns; go to DONE.
- DONE:
  - out_valid=1, rk_idx=0.
  - plaintext and state_reg are held stable while out_ready=0 (backpressure, no limit).
  - On out_ready: go to IDLE.
  - in_ready=0 in DONE; the next accept occurs in IDLE at the earliest one cycle later.
- Latency: acceptance at edge T gives out_valid=1 after edge T+10, i.e. 10 cycles.
- Minimum spacing between accepts: 12 cycles, when out_ready is held high.
- ciphertext is sampled only on the accept edge; later changes on that input are ignored.
- in_valid while not in IDLE is ignored, with no loss of core state; the producer holds the request.
- rk is sampled every cycle in IDLE-accept and ROUND. The key store must present the key for rk_idx combinationally.
- Reset mid-operation, in ROUND or DONE:
  - Aborts the block, returns to IDLE with the reset values above.
  - out_valid falls on the next edge and no partial plaintext is emitted.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.
- plaintext equals state_reg at all times. It is meaningful only while out_valid=1.

Test Plan:
- FIPS-197 C.1 decrypt: key 000102030405060708090a0b0c0d0e0f expanded in the bench key store, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> rk_idx sequence 10,9,...,0 over the accept and round cycles; out_valid high exactly 10 cycles after accept; plaintext=00112233445566778899aabbccddeeff; busy low again the following cycle.
- First-edge check with the same key: state_reg after the accept edge = 69c4e0d86a7b0430d8cdb78070b4c55a ^ 13111d7fe3944a17f307a78b4d2b30c5 = 7ad5fda789ef4e272bca100b3d9ff59f.
- Backpressure: out_ready=0 for 20 cycles after DONE -> out_valid stays 1, plaintext stable at 00112233445566778899aabbccddeeff, in_ready=0. Raise out_ready -> IDLE next cycle.
- Back-to-back: two ciphertexts offered with in_valid held high, out_ready=1 -> second accepted exactly 12 cycles after first; both plaintexts correct; the second ciphertext is not accepted while busy.
- Reset mid-round: assert rst for 1 cycle at round counter 5 -> next cycle IDLE, out_valid=0, state_reg=0, in_ready=1. A fresh C.1 block then decrypts correctly.
- Random regression: 1000 random key/ciphertext pairs against a software AES-128 model, with random out_ready stalls -> all plaintexts match and no handshake is dropped or duplicated.
